// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder
// Memory slave for the picorv32 native memory interface. Word-organised RAM with
// byte-strobe writes, a fixed number of wait states, a preload port that works
// independently of reset, a store monitor, and sticky error / transfer-count status.
module picorv32_mem_responder #(
    parameter  int MEM_WORDS   = 256,
    parameter  int WAIT_CYCLES = 0,
    localparam int AW          = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic          mem_instr,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          wr_mon_valid,
    output logic [31:0]   wr_mon_addr,
    output logic [31:0]   wr_mon_data,
    output logic [3:0]    wr_mon_strb,
    output logic          bus_err,
    output logic [31:0]   access_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic [31:0]   ram [MEM_WORDS];

    logic          accept;
    logic          do_resp;
    logic          in_range;
    logic [AW-1:0] word_idx;

    // Fetch/data distinction is carried on the bus but does not alter behaviour.
    logic unused_instr;
    assign unused_instr = mem_instr;

    // While mem_ready is high the CPU still holds mem_valid for that beat, so a
    // fresh request is only taken once the ready pulse has gone.
    assign accept   = (state == IDLE) && mem_valid && !mem_ready;
    assign do_resp  = (state == RESP);
    assign in_range = (req_addr < BYTE_LIMIT);
    assign word_idx = req_addr[AW+1:2];

    // Request capture: fields are frozen at acceptance, later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
        end
    end

    // Transaction sequencer: IDLE -> (WAIT countdown) -> RESP -> IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port: byte-lane CPU store in RESP, then preload; the later assignment
    // lets a preload override a store to the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (do_resp && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) ram[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
        if (load_en) ram[load_addr] <= load_data;
    end

    // Response, store monitor and status registers, all updated on the RESP edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready    <= 1'b0;
            mem_rdata    <= 32'd0;
            wr_mon_valid <= 1'b0;
            wr_mon_addr  <= 32'd0;
            wr_mon_data  <= 32'd0;
            wr_mon_strb  <= 4'd0;
            bus_err      <= 1'b0;
            access_cnt   <= 32'd0;
        end else begin
            mem_ready    <= do_resp;
            wr_mon_valid <= do_resp && (req_wstrb != 4'd0);
            if (do_resp) begin
                mem_rdata <= in_range ? ram[word_idx] : 32'd0;
                if (!in_range) bus_err <= 1'b1;
                if (access_cnt != 32'hFFFF_FFFF) access_cnt <= access_cnt + 32'd1;
                if (req_wstrb != 4'd0) begin
                    wr_mon_addr <= req_addr;
                    wr_mon_data <= req_wdata;
                    wr_mon_strb <= req_wstrb;
                end
            end
        end
    end

endmodule
